// File: rtl/ipif_regbank_pkg.sv
// Shared types and elaboration helpers for ipif_register_bank.
// Defining IPIF_REGBANK_IRQ_EN adds one IRQ-enable register (IRQ_REGS = 1) and an irq output.
package ipif_regbank_pkg;

  typedef enum logic [1:0] {KIND_RW, KIND_SR, KIND_W1C, KIND_RO} bit_kind_e;

`ifdef IPIF_REGBANK_IRQ_EN
  localparam int IRQ_REGS = 1;
`else
  localparam int IRQ_REGS = 0;
`endif

  function automatic bit_kind_e kind_of(input logic rw, input logic sr, input logic w1c);
    bit_kind_e kind;
    if (rw)       kind = sr ? KIND_SR : KIND_RW;
    else if (w1c) kind = KIND_W1C;
    else          kind = KIND_RO;
    return kind;
  endfunction

  // Never returns 0 so a one-entry bank still gets a 1-bit select.
  function automatic int clog2(input int value);
    int bits = 1;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

  function automatic int be_w(input int data_width);
    return data_width / 8;
  endfunction

  // SR must sit inside RW, and W1C must not overlap RW.
  function automatic logic mask_bit_ok(input logic rw, input logic sr, input logic w1c);
    return !(sr && !rw) && !(w1c && rw);
  endfunction

endpackage

// File: rtl/ipif_pulse_timer.sv
// Per-register hold timer for self-resetting bits: a load restarts the count and
// expire strobes on the edge where the count reaches zero.
module ipif_pulse_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] pulse_cycles,
  output logic        expire
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (load) begin
      cnt_d = pulse_cycles;
    end else if (cnt_q != 16'd0) begin
      cnt_d  = cnt_q - 16'd1;
      expire = (cnt_q == 16'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 16'd0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ipif_register_bank.sv
// IPIF slave register bank with per-bit RW / SR / W1C / RO behaviour, byte enables and
// range error reporting. Optional IRQ-enable register and irq output under IPIF_REGBANK_IRQ_EN.
module ipif_register_bank
  import ipif_regbank_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int N_REG = 4,
  parameter int USE_ONEHOT_READ = 1,
  parameter int ADDR_LSB = 2,
  parameter logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] DEFAULTS = '0,
  parameter logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] RW_MASK  = '1,
  parameter logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] SR_MASK  = '0,
  parameter logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] W1C_MASK = '0,
  parameter int PULSE_CYCLES = 1
) (
  input  logic                                clk,
  input  logic                                IPIF_bus2ip_resetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       IPIF_bus2ip_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       IPIF_bus2ip_data,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     IPIF_bus2ip_be,
  input  logic [N_REG+IRQ_REGS-1:0]           IPIF_bus2ip_rdce,
  input  logic [N_REG+IRQ_REGS-1:0]           IPIF_bus2ip_wrce,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       IPIF_ip2bus_data,
  output logic                                IPIF_ip2bus_rdack,
  output logic                                IPIF_ip2bus_wrack,
  output logic                                IPIF_ip2bus_error,
  output logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] parameters_out,
  input  logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] parameters_in,
  input  logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] events_in
`ifdef IPIF_REGBANK_IRQ_EN
  ,
  output logic                                irq
`endif
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int BW = be_w(DW);
  localparam int NR = N_REG + IRQ_REGS;
  localparam int IW = clog2(NR);
  localparam logic [AW-1:0] NR_A = AW'(NR);

  localparam logic [N_REG-1:0][DW-1:0] RW_M   = RW_MASK;
  localparam logic [N_REG-1:0][DW-1:0] SR_M   = SR_MASK;
  localparam logic [N_REG-1:0][DW-1:0] W1C_M  = W1C_MASK;
  localparam logic [N_REG-1:0][DW-1:0] DEF_M  = DEFAULTS;
  localparam logic [N_REG-1:0][DW-1:0] RST_M  = DEFAULTS & RW_MASK;

  logic [N_REG-1:0][DW-1:0] param_q, param_d, sticky_q, sticky_d, ro_m;
  logic [N_REG-1:0][DW-1:0] pin, evt;
  logic [NR-1:0][DW-1:0]    word;
  logic [DW-1:0]            be_mask;
  logic [N_REG-1:0]         wr_en, expire;
  logic [AW-1:0]            addr_idx;
  logic                     addr_oor, rd_any, wr_any;
  logic [IW-1:0]            rd_sel;
  logic [DW-1:0]            rdata_q, rdata_d;
  logic                     rdack_q, rdack_d, wrack_q, wrack_d, error_q, error_d;

  if ((DW % 8) != 0 || N_REG < 1 || N_REG > 64 || PULSE_CYCLES < 1 || PULSE_CYCLES > 65535)
  begin : g_bad_params
    $error("ipif_register_bank: parameter out of range");
  end

  assign pin = parameters_in;
  assign evt = events_in;

  genvar gi, gb;
  for (gi = 0; gi < BW; gi++) begin : g_be
    assign be_mask[gi*8 +: 8] = {8{IPIF_bus2ip_be[gi]}};
  end

  for (gi = 0; gi < N_REG; gi++) begin : g_reg
    for (gb = 0; gb < DW; gb++) begin : g_bit
      localparam bit_kind_e KIND = kind_of(RW_M[gi][gb], SR_M[gi][gb], W1C_M[gi][gb]);
      if (!mask_bit_ok(RW_M[gi][gb], SR_M[gi][gb], W1C_M[gi][gb])) begin : g_bad_mask
        $error("ipif_register_bank: inconsistent masks at register %0d bit %0d", gi, gb);
      end
      assign ro_m[gi][gb] = (KIND == KIND_RO);
    end

    ipif_pulse_timer u_timer (
      .clk         (clk),
      .rst_n       (IPIF_bus2ip_resetn),
      .load        (wr_en[gi]),
      .pulse_cycles(16'(PULSE_CYCLES)),
      .expire      (expire[gi])
    );

    assign word[gi] = (param_q[gi] & RW_M[gi]) | (sticky_q[gi] & W1C_M[gi]) | (pin[gi] & ro_m[gi]);
  end

  // Range checking only exists in address mode; onehot mode never flags an error.
  assign addr_idx = IPIF_bus2ip_addr >> ADDR_LSB;
  assign addr_oor = (USE_ONEHOT_READ == 0) && (addr_idx >= NR_A);
  assign rd_any   = |IPIF_bus2ip_rdce;
  assign wr_any   = |IPIF_bus2ip_wrce;
  assign wr_en    = IPIF_bus2ip_wrce[N_REG-1:0] & {N_REG{!addr_oor}};

  always_comb begin
    param_d  = param_q;
    sticky_d = sticky_q;
    for (int i = 0; i < N_REG; i++) begin
      if (expire[i]) param_d[i] = (param_q[i] & ~SR_M[i]) | (DEF_M[i] & SR_M[i]);
      if (wr_en[i]) begin
        param_d[i]  = (param_d[i] & ~(be_mask & RW_M[i])) | (IPIF_bus2ip_data & be_mask & RW_M[i]);
        sticky_d[i] = sticky_q[i] & ~(IPIF_bus2ip_data & be_mask & W1C_M[i]);
      end
      // Events OR in after the clear so a coincident event is never lost.
      sticky_d[i] = sticky_d[i] | (evt[i] & W1C_M[i]);
    end
  end

  always_comb begin
    rd_sel = '0;
    if (USE_ONEHOT_READ != 0) begin
      for (int i = 0; i < NR; i++) begin
        if (IPIF_bus2ip_rdce[i]) rd_sel = IW'(i);
      end
    end else begin
      rd_sel = addr_idx[IW-1:0];
    end
    rdata_d = (rd_any && !addr_oor) ? word[rd_sel] : '0;
    rdack_d = rd_any;
    wrack_d = wr_any;
    error_d = addr_oor && (rd_any || wr_any);
  end

  always_ff @(posedge clk or negedge IPIF_bus2ip_resetn) begin
    if (!IPIF_bus2ip_resetn) begin
      param_q  <= RST_M;
      sticky_q <= '0;
      rdata_q  <= '0;
      rdack_q  <= 1'b0;
      wrack_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      param_q  <= param_d;
      sticky_q <= sticky_d;
      rdata_q  <= rdata_d;
      rdack_q  <= rdack_d;
      wrack_q  <= wrack_d;
      error_q  <= error_d;
    end
  end

`ifdef IPIF_REGBANK_IRQ_EN
  // Enable bit b gates sticky bit b of every register.
  logic [DW-1:0] irq_en_q, irq_en_d;
  logic          irq_q, irq_d;

  always_comb begin
    irq_en_d = irq_en_q;
    if (IPIF_bus2ip_wrce[N_REG] && !addr_oor)
      irq_en_d = (irq_en_q & ~be_mask) | (IPIF_bus2ip_data & be_mask);
    irq_d = 1'b0;
    for (int i = 0; i < N_REG; i++) irq_d = irq_d | (|(sticky_q[i] & irq_en_q));
  end

  always_ff @(posedge clk or negedge IPIF_bus2ip_resetn) begin
    if (!IPIF_bus2ip_resetn) begin
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign word[N_REG] = irq_en_q;
  assign irq         = irq_q;
`endif

  assign parameters_out    = param_q;
  assign IPIF_ip2bus_data  = rdata_q;
  assign IPIF_ip2bus_rdack = rdack_q;
  assign IPIF_ip2bus_wrack = wrack_q;
  assign IPIF_ip2bus_error = error_q;

endmodule

// File: doc/ipif_register_bank.md
Name: ipif_register_bank

Overview:
- Parametrised successor to the IPIF parameter register decoder. Same IPIF slave side, generalised per bit.
- Each bit of each 32-bit register is one of four kinds:
  - RW: plain read/write.
  - SR: self-resetting pulse bit with a programmable hold time.
  - W1C: sticky status bit, set by hardware events, cleared by writing 1.
  - RO: read-only, driven by hardware.
- Adds byte-enable writes, composed readback and address-range error reporting.
- Sits between the AXI-Lite-to-IPIF bridge and the user logic of a firmware IP block.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, bus data width; multiple of 8.
- C_S_AXI_ADDR_WIDTH, 32, bus address width.
- N_REG, 4, number of registers; 1..64.
- USE_ONEHOT_READ, 1, 1 = select the read register from rdce; 0 = decode it from the address.
- ADDR_LSB, 2, byte-address bits dropped when decoding the address (addr mode only).
- DEFAULTS, all 0, N_REG*DW bits; reset/return value of RW and SR bits.
- RW_MASK, all 1, N_REG*DW bits; 1 = bit is RW or SR.
- SR_MASK, all 0, N_REG*DW bits; 1 = bit is SR. Must be a subset of RW_MASK.
- W1C_MASK, all 0, N_REG*DW bits; 1 = bit is W1C. Must be disjoint from RW_MASK.
- PULSE_CYCLES, 1, SR hold time in clocks; 1..65535.
- Any bit in none of the masks is RO.

Ports:
- clk  in  1  bus clock.
- IPIF_bus2ip_resetn  in  1  asynchronous active-low reset.
- IPIF_bus2ip_addr  in  C_S_AXI_ADDR_WIDTH  byte address.
- IPIF_bus2ip_data  in  C_S_AXI_DATA_WIDTH  write data.
- IPIF_bus2ip_be  in  C_S_AXI_DATA_WIDTH/8  write byte enables.
- IPIF_bus2ip_rdce  in  N_REG  read chip enables.
- IPIF_bus2ip_wrce  in  N_REG  write chip enables.
- IPIF_ip2bus_data  out  C_S_AXI_DATA_WIDTH  registered read data.
- IPIF_ip2bus_rdack  out  1  read acknowledge.
- IPIF_ip2bus_wrack  out  1  write acknowledge.
- IPIF_ip2bus_error  out  1  address out of range; asserted together with an ack.
- parameters_out  out  N_REG*DW  current RW/SR values; W1C and RO positions driven 0.
- parameters_in  in  N_REG*DW  RO status from user logic.
- events_in  in  N_REG*DW  W1C set strobes; sampled every clock.

Behaviour:
- Reset, asynchronous on IPIF_bus2ip_resetn low:
  - parameters_out = DEFAULTS & RW_MASK.
  - Sticky bits = 0; pulse counters = 0.
  - IPIF_ip2bus_data = 0; rdack, wrack and error = 0.
- Reset release: first active edge is the first clock with IPIF_bus2ip_resetn high.
- Write acknowledge:
  - wrack = 1 exactly one cycle after any clock with a wrce bit set.
  - Multiple wrce bits set: every selected register is written.
- Write effect, per byte lane b with be[b]=1:
  - RW bits take the write data.
  - W1C bits written as 1 clear; written as 0 are unchanged.
  - RO bits are ignored.
  - Lanes with be=0 are untouched, including W1C bits.
- SR bits:
  - A write loads the written value and loads that register's counter with PULSE_CYCLES.
  - The counter decrements each clock. When it reaches 0, every SR bit of the register returns to DEFAULTS in the same edge.
  - A new write while the counter is nonzero reloads it (restart); the newest data wins.
  - PULSE_CYCLES=1: an SR bit written 1 is high for exactly one cycle.
- W1C bits:
  - Set when the events_in bit is 1; hold until cleared.
  - Set and clear in the same cycle: set wins (no lost event).
- Read data composition, per bit: RW/SR bits from parameters_out, W1C bits from sticky, RO bits from parameters_in.
- Read select:
  - Onehot mode: the highest set rdce index selects the register.
  - Address mode: index = addr >> ADDR_LSB. Index >= N_REG returns data 0 and error=1.
- Read timing:
  - IPIF_ip2bus_data and rdack update one cycle after rdce. Latency 1, no wait states.
  - rdack = |rdce, delayed one cycle.
- error:
  - Asserted only with rdack or wrack.
  - Address mode only: set when the decoded index is out of range (read or write); an out-of-range write changes nothing.
  - Always 0 in onehot mode.
- Simultaneous read and write of the same register: the read returns the pre-write value.
- Reset mid-pulse: the counter and SR bits go to reset values immediately.

Optional Feature:
- Macro: IPIF_REGBANK_IRQ_EN.
- Defined:
  - Adds an IRQ-enable register at index N_REG, all RW, default 0.
  - Adds output irq (1 bit) = registered OR over (sticky & enable). One-cycle latency from the sticky bit being set.
  - rdce/wrce widths become N_REG+1.
  - Address-mode range check becomes index > N_REG.
- Undefined: no irq port, no extra register; widths as listed above.

Decomposition:
- Package ipif_regbank_pkg:
  - bit-kind enum {RW, SR, W1C, RO};
  - function kind_of(mask bits);
  - clog2 helper;
  - BE_W constant function;
  - mask-consistency check function used in an initial assertion.
- Sub-module ipif_pulse_timer: one per register.
  - Inputs: load and PULSE_CYCLES.
  - Output: expire strobe.
  - 16-bit down-counter.

Test Plan:
- Reset, then read all registers with DEFAULTS = 32'hA5 in reg0 -> reg0 reads 32'h000000A5 and rdack lasts 1 cycle; parameters_out matches.
- Write 32'h11223344 to reg1 with be=4'b0101 over a prior value of 0 -> reg1 reads 32'h00220044; wrack one cycle after wrce.
- Reg2 bit0 SR, PULSE_CYCLES=3: write 1 -> parameters_out bit0 high exactly 3 cycles. Rewrite 1 at cycle 2 -> high 5 cycles total.
- Reg3 W1C: pulse events_in bit4 -> reads 32'h10. Write 32'h10 in the same cycle as a new events_in bit4 -> bit stays 1. Write 32'h10 with no event -> reads 0.
- Address mode, N_REG=4: read addr 32'h10 -> data 0 and error=1 with rdack. Write addr 32'h10 -> no register changes, error=1 with wrack.
- Assert reset during an active pulse and with sticky bits set -> all outputs at reset values immediately; after release, the first read returns DEFAULTS.
